instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: prefetch buffer entries; legal values are 2 and 4.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  read strobe to the instruction memory.
REQ-006 imem_addr  out  32  byte address of the read; bits [1:0] are always 0.
REQ-007 imem_rdata  in  32  read data, valid exactly 1 cycle after imem_req=1.
REQ-008 redirect_valid  in  1  branch/jump taken; 1-cycle pulse.
REQ-009 redirect_pc  in  32  target address, sampled when redirect_valid=1.
REQ-010 out_valid  out  1  an instruction is presented to the decode/execute stage.
REQ-011 out_ready  in  1  the consumer accepts; transfer occurs when out_valid & out_ready.
REQ-012 out_instr  out  32  instruction word.
REQ-013 out_pc  out  32  address of out_instr.

Function
REQ-014 The block SHALL hold fetch_pc and issue imem_req=1 with imem_addr=fetch_pc only when (fifo_count + inflight) < FIFO_DEPTH and redirect_valid=0.
REQ-015 Each issue SHALL advance fetch_pc by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-016 The response from the previous cycle's request SHALL be written to the FIFO as {pc, imem_rdata}, unless that request was squashed.
REQ-017 The FIFO SHALL present in order; out_* SHALL be driven from the head entry, and out_valid = (count != 0).
REQ-018 Push and pop in the same cycle SHALL leave count unchanged; a full FIFO SHALL never be pushed, which is guaranteed by REQ-014.
REQ-019 out_instr/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 redirect_valid=1 SHALL, at that edge: flush the FIFO (out_valid=0 next cycle), squash any inflight response, and set fetch_pc = {redirect_pc[31:2],2'b00}; no request is issued in the redirect cycle.
REQ-021 A redirect takes priority over any simultaneous pop, push, or issue.
REQ-022 Latency SHALL be: request in cycle N, data in the FIFO at the end of N+1, out_valid=1 in N+2; a redirect-to-valid time of 3 cycles.
REQ-023 Steady state with out_ready=1 constantly SHALL sustain 1 instruction per cycle.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set fetch_pc=RESET_PC, empty the FIFO, clear inflight, and drive out_valid=0 and imem_req=0 in the following cycle.
REQ-025 out_instr and out_pc SHALL reset to 0.
REQ-026 rst asserted mid-stream SHALL discard the inflight response; the first request after release SHALL use RESET_PC.

Configuration
REQ-027 With FETCH_STEP_EN defined, the block SHALL have an extra input step (1 bit), and issue SHALL additionally require a step credit: each rising-edge-detected step pulse grants exactly one issue, and credits do not accumulate beyond 1.
REQ-028 Without FETCH_STEP_EN, no step port SHALL exist and issue SHALL be free-running per REQ-014.

Structure
REQ-029 Package fetch_pkg SHALL hold INSTR_W=32, ADDR_W=32, PC_STEP=4, and the typedef fetch_entry_t {pc, instr}.
REQ-030 The FIFO SHALL be a sub-module, fetch_fifo (parameter DEPTH; push/pop/flush; full/empty/count).

Verification
REQ-031 Reset release with RESET_PC=0, out_ready=1, memory word[i]=i -> imem_addr 0,4,8..., out_pc 0,4,8 with out_instr 0,1,2 from cycle 3, one per cycle.
REQ-032 out_ready=0 for 5 cycles -> at most FIFO_DEPTH words buffered, imem_req=0 while full, out_instr stable; on release, no word is lost or duplicated.
REQ-033 redirect_valid=1 with redirect_pc=32'h40 while 2 words are buffered and 1 is inflight -> out_valid=0 next cycle, then out_pc=32'h40 after 3 cycles, and none of the old words appear.
REQ-034 redirect_pc=32'h43 -> the next fetch is at 32'h40.
REQ-035 fetch_pc at 32'hFFFF_FFFC -> the next out_pc is 0.
REQ-036 With FETCH_STEP_EN defined, 3 step pulses -> exactly 3 instructions (pc 0,4,8) delivered, and imem_req stays idle otherwise.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and the prefetch buffer entry type for the instruction fetch stage.
// Used by instr_fetch (optional FETCH_STEP_EN build) and fetch_fifo.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer holding {pc, instr} entries; flush empties it in one edge.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign do_pop = pop & ~empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential reads, buffers responses, handles redirects.
// Defining FETCH_STEP_EN adds a 'step' input that gates each issue by a one-shot credit.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef FETCH_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              rst_hold;
    logic              issue;
    logic              room;
    logic              credit_ok;
    logic              pop;
    logic              push;
    logic [CW:0]       occupancy;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      fifo_head;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = inflight & (~fifo_full | pop);

    // A same-cycle pop frees a slot, which keeps one instruction per cycle flowing.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign room      = (occupancy < (CW+1)'(FIFO_DEPTH));
    assign issue     = room & ~redirect_valid & ~rst_hold & credit_ok;

    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;
    assign push_entry = '{pc: inflight_pc, instr: imem_rdata};
    assign out_instr  = fifo_head.instr;
    assign out_pc     = fifo_head.pc;

    // rst_hold keeps the request line quiet for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC & ~ADDR_W'(3);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rst_hold    <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~ADDR_W'(3);
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    inflight_pc <= fetch_pc;
                    fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
                end
            end
        end
    end

`ifdef FETCH_STEP_EN
    logic step_d;
    logic step_credit;

    // A rising edge on step grants one issue; an unused credit is not stacked.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_d      <= 1'b0;
            step_credit <= 1'b0;
        end else begin
            step_d      <= step;
            step_credit <= (step_credit & ~issue) | (step & ~step_d);
        end
    end

    assign credit_ok = step_credit;
`else
    assign credit_ok = 1'b1;
`endif

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (FIFO_DEPTH=4) against a one-cycle-latency memory, word[i]=i.
// With FETCH_STEP_EN defined only the step-credit sequence runs after reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_STEP_EN
    logic        step;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef FETCH_STEP_EN
        .step          (step),
`endif
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    // Memory returns the word index of the requested address one cycle later.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? {2'b00, imem_addr[31:2]} : 32'hDEAD_BEEF;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
`ifdef FETCH_STEP_EN
        step           = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", out_valid, 1'b0);
        check_output("rst_req", imem_req, 1'b0);
        check_output("rst_pc", out_pc, 32'h0);
        check_output("rst_instr", out_instr, 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        settle();
        check_output("post_rst_req", imem_req, 1'b0);

`ifdef FETCH_STEP_EN
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            step = 1'b1;
            settle();
            check_output("step_idle_req", imem_req, 1'b0);
            next_cycle();
            step = 1'b0;
            settle();
            check_output("step_req", imem_req, 1'b1);
            check_output("step_addr", imem_addr, 32'(4 * k));
            next_cycle();
            check_output("step_gap_req", imem_req, 1'b0);
            next_cycle();
            check_output("step_valid", out_valid, 1'b1);
            check_output("step_pc", out_pc, 32'(4 * k));
            check_output("step_instr", out_instr, 32'(k));
            check_output("step_hold_req", imem_req, 1'b0);
            next_cycle();
            check_output("step_empty", out_valid, 1'b0);
            check_output("step_end_req", imem_req, 1'b0);
        end
`else
        // Streaming from reset: one instruction per cycle from cycle 3.
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            check_output("stream_req", imem_req, 1'b1);
            check_output("stream_addr", imem_addr, 32'(4 * (k - 1)));
            if (k >= 3) begin
                check_output("stream_valid", out_valid, 1'b1);
                check_output("stream_pc", out_pc, 32'(4 * (k - 3)));
                check_output("stream_instr", out_instr, 32'(k - 3));
            end
        end

        // Consumer stall: buffer fills to four entries, head stays put.
        next_cycle();
        out_ready = 1'b0;
        settle();
        check_output("stall_req0", imem_req, 1'b1);
        check_output("stall_addr0", imem_addr, 32'd32);
        check_output("stall_pc0", out_pc, 32'd24);
        next_cycle();
        check_output("stall_req1", imem_req, 1'b1);
        check_output("stall_addr1", imem_addr, 32'd36);
        check_output("stall_pc1", out_pc, 32'd24);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check_output("full_req", imem_req, 1'b0);
            check_output("full_valid", out_valid, 1'b1);
            check_output("full_pc", out_pc, 32'd24);
            check_output("full_instr", out_instr, 32'd6);
        end
        next_cycle();
        out_ready = 1'b1;
        settle();
        check_output("release_req", imem_req, 1'b1);
        check_output("release_addr", imem_addr, 32'd40);
        check_output("release_pc", out_pc, 32'd24);
        for (int j = 1; j <= 3; j++) begin
            next_cycle();
            check_output("drain_pc", out_pc, 32'(24 + 4 * j));
            check_output("drain_instr", out_instr, 32'(6 + j));
            check_output("drain_addr", imem_addr, 32'(40 + 4 * j));
        end

        // Redirect to 0x200, then build up two buffered words and one inflight.
        next_cycle();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        settle();
        check_output("redir_cycle_req", imem_req, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        check_output("flush_valid", out_valid, 1'b0);
        check_output("redir_addr0", imem_addr, 32'h200);
        next_cycle();
        check_output("flush_valid1", out_valid, 1'b0);
        check_output("redir_addr1", imem_addr, 32'h204);
        next_cycle();
        check_output("redir_first_valid", out_valid, 1'b1);
        check_output("redir_first_pc", out_pc, 32'h200);
        check_output("redir_first_instr", out_instr, 32'h80);
        check_output("redir_addr2", imem_addr, 32'h208);

        // Redirect to 0x40 with 0x200/0x204 buffered and 0x208 inflight.
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        settle();
        check_output("redir2_req", imem_req, 1'b0);
        check_output("redir2_hold_pc", out_pc, 32'h200);
        next_cycle();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        settle();
        check_output("redir2_flush", out_valid, 1'b0);
        check_output("redir2_addr", imem_addr, 32'h40);
        next_cycle();
        check_output("redir2_empty", out_valid, 1'b0);
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            check_output("redir2_valid", out_valid, 1'b1);
            check_output("redir2_pc", out_pc, 32'(32'h40 + 4 * j));
            check_output("redir2_instr", out_instr, 32'(32'h10 + j));
        end

        // Misaligned target is rounded down to a word boundary.
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        settle();
        check_output("align_redir_req", imem_req, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        check_output("align_addr", imem_addr, 32'h40);
        check_output("align_flush", out_valid, 1'b0);
        next_cycle();
        next_cycle();
        check_output("align_pc", out_pc, 32'h40);

        // Address wrap from the top of the address space to zero.
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        settle();
        next_cycle();
        redirect_valid = 1'b0;
        settle();
        check_output("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        check_output("wrap_addr1", imem_addr, 32'h0);
        next_cycle();
        check_output("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        check_output("wrap_instr0", out_instr, 32'h3FFF_FFFF);
        next_cycle();
        check_output("wrap_pc1", out_pc, 32'h0);
        check_output("wrap_instr1", out_instr, 32'h0);

        // Mid-stream reset discards everything and restarts at RESET_PC.
        next_cycle();
        rst = 1'b1;
        settle();
        next_cycle();
        rst = 1'b0;
        settle();
        check_output("mid_rst_valid", out_valid, 1'b0);
        check_output("mid_rst_req", imem_req, 1'b0);
        check_output("mid_rst_pc", out_pc, 32'h0);
        check_output("mid_rst_instr", out_instr, 32'h0);
        next_cycle();
        check_output("restart_req", imem_req, 1'b1);
        check_output("restart_addr", imem_addr, 32'h0);
        next_cycle();
        check_output("restart_addr1", imem_addr, 32'h4);
        next_cycle();
        check_output("restart_valid", out_valid, 1'b1);
        check_output("restart_pc", out_pc, 32'h0);
        next_cycle();
        check_output("restart_pc1", out_pc, 32'h4);
        check_output("restart_instr1", out_instr, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
